// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: request codes, miss FSM
// states and the address-split width helpers.
package cache_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int offset_bits(input int line_width);
    return clog2(line_width / 8);
  endfunction

  function automatic int index_bits(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_size, input int line_width, input int sets);
    return addr_size - index_bits(sets) - offset_bits(line_width);
  endfunction

  // A direct-mapped configuration still carries one (constant zero) pointer bit.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Replacement choice for one set: lowest-numbered invalid way, otherwise the
// set's round-robin pointer.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int  WAYS  = 2,
  localparam int WAY_W = way_bits(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr,
  output logic [WAY_W-1:0] victim
);

  always_comb begin
    victim = rr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) victim = WAY_W'(i);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with a two-step miss
// FSM (optional writeback, then fill) talking to memory over valid/ack.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int    ADDR_SIZE  = 32,
  parameter int    LINE_WIDTH = 128,
  parameter int    SETS       = 4,
  parameter int    WAYS       = 2,
  parameter string CACHE_TYPE = "DATA"
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  write_or_read,
  input  logic [ADDR_SIZE-1:0]  address,
  input  logic [LINE_WIDTH-1:0] in_data,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  ready,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [ADDR_SIZE-1:0]  mem_req_address,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int OFF_W = offset_bits(LINE_WIDTH);
  localparam int IDX_W = index_bits(SETS);
  localparam int TAG_W = tag_bits(ADDR_SIZE, LINE_WIDTH, SETS);
  localparam int WAY_W = way_bits(WAYS);

  logic [LINE_WIDTH-1:0]      data_q [SETS][WAYS];
  logic [TAG_W-1:0]           tag_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
  logic [WAY_W-1:0] victim_q, victim_d;

  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_req_write_q, mem_req_write_d;
  logic [ADDR_SIZE-1:0]  mem_req_address_q, mem_req_address_d;
  logic [LINE_WIDTH-1:0] mem_req_data_q, mem_req_data_d;

  logic                  data_we, tag_we;
  logic [IDX_W-1:0]      wr_idx;
  logic [WAY_W-1:0]      wr_way;
  logic [LINE_WIDTH-1:0] wr_data;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way, victim_w;
  logic             unused_offset, unused_cache_type;

  assign req_idx = address[OFF_W +: IDX_W];
  assign req_tag = address[ADDR_SIZE-1 -: TAG_W];
  assign unused_offset = ^address[OFF_W-1:0];
  assign unused_cache_type = (CACHE_TYPE == "");

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_tag_cmp
      assign hit_vec[gi] = valid_q[req_idx][gi] && (tag_q[req_idx][gi] == req_tag);
    end
  endgenerate

  assign hit = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
    end
  end

  cache_victim_select #(.WAYS(WAYS)) u_victim_select (
    .valid  (valid_q[req_idx]),
    .rr     (rr_q[req_idx]),
    .victim (victim_w)
  );

  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_write   = mem_req_write_q;
  assign mem_req_address = mem_req_address_q;
  assign mem_req_data    = mem_req_data_q;

  always_comb begin
    state_d           = state_q;
    lat_tag_d         = lat_tag_q;
    lat_idx_d         = lat_idx_q;
    victim_d          = victim_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    rr_d              = rr_q;
    mem_req_valid_d   = mem_req_valid_q;
    mem_req_write_d   = mem_req_write_q;
    mem_req_address_d = mem_req_address_q;
    mem_req_data_d    = mem_req_data_q;
    data_we           = 1'b0;
    tag_we            = 1'b0;
    wr_idx            = req_idx;
    wr_way            = hit_way;
    wr_data           = in_data;
    ready             = 1'b0;
    out_data          = '0;

    case (state_q)
      IDLE: begin
        ready = !enable || hit;
        if (hit) out_data = data_q[req_idx][hit_way];
        if (enable && hit && (write_or_read == WRITE)) begin
          data_we = 1'b1;
          dirty_d[req_idx][hit_way] = 1'b1;
        end else if (enable && !hit) begin
          lat_tag_d       = req_tag;
          lat_idx_d       = req_idx;
          victim_d        = victim_w;
          mem_req_valid_d = 1'b1;
          if (valid_q[req_idx][victim_w] && dirty_q[req_idx][victim_w]) begin
            state_d           = WRITEBACK;
            mem_req_write_d   = 1'b1;
            mem_req_address_d = {tag_q[req_idx][victim_w], req_idx, {OFF_W{1'b0}}};
            mem_req_data_d    = data_q[req_idx][victim_w];
          end else begin
            state_d           = FILL;
            mem_req_write_d   = 1'b0;
            mem_req_address_d = {req_tag, req_idx, {OFF_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          dirty_d[lat_idx_q][victim_q] = 1'b0;
          state_d           = FILL;
          mem_req_write_d   = 1'b0;
          mem_req_address_d = {lat_tag_q, lat_idx_q, {OFF_W{1'b0}}};
        end
      end
      FILL: begin
        if (mem_ack) begin
          data_we = 1'b1;
          tag_we  = 1'b1;
          wr_idx  = lat_idx_q;
          wr_way  = victim_q;
          wr_data = mem_rdata;
          valid_d[lat_idx_q][victim_q] = 1'b1;
          dirty_d[lat_idx_q][victim_q] = 1'b0;
          // Power-of-two way count: natural overflow gives the modulo wrap.
          rr_d[lat_idx_q] = (WAYS > 1) ? rr_q[lat_idx_q] + 1'b1 : '0;
          state_d         = IDLE;
          mem_req_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      valid_q           <= '0;
      dirty_q           <= '0;
      rr_q              <= '0;
      lat_tag_q         <= '0;
      lat_idx_q         <= '0;
      victim_q          <= '0;
      mem_req_valid_q   <= 1'b0;
      mem_req_write_q   <= 1'b0;
      mem_req_address_q <= '0;
      mem_req_data_q    <= '0;
    end else begin
      state_q           <= state_d;
      valid_q           <= valid_d;
      dirty_q           <= dirty_d;
      rr_q              <= rr_d;
      lat_tag_q         <= lat_tag_d;
      lat_idx_q         <= lat_idx_d;
      victim_q          <= victim_d;
      mem_req_valid_q   <= mem_req_valid_d;
      mem_req_write_q   <= mem_req_write_d;
      mem_req_address_q <= mem_req_address_d;
      mem_req_data_q    <= mem_req_data_d;
    end
  end

  // Line storage carries no reset; the valid bits guard it.
  always_ff @(posedge clock) begin
    if (data_we) data_q[wr_idx][wr_way] <= wr_data;
    if (tag_we)  tag_q[wr_idx][wr_way]  <= lat_tag_q;
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench: scenario tasks plus randomized traffic, checked against
// a line-level cache model and a sparse memory model.
module tb_set_assoc_cache;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        write_or_read = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] in_data = '0;
  logic [31:0] out_data;
  logic        ready;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [15:0] mem_req_address;
  logic [31:0] mem_req_data;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  set_assoc_cache #(
    .ADDR_SIZE(16), .LINE_WIDTH(32), .SETS(4), .WAYS(2), .CACHE_TYPE("DATA")
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .write_or_read(write_or_read),
    .address(address), .in_data(in_data), .out_data(out_data), .ready(ready),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_address(mem_req_address), .mem_req_data(mem_req_data),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Reference model: set = addr[3:2], tag = addr[15:4], line = 4 bytes.
  bit          m_valid [4][2];
  bit          m_dirty [4][2];
  logic [11:0] m_tag   [4][2];
  logic [31:0] m_data  [4][2];
  int          m_rr    [4];
  logic [31:0] mem [logic [15:0]];

  function automatic logic [31:0] mem_read(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
  endtask

  task automatic access(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input int delay, input bit drop_en, input string name);
    int s, hitw, vic, way, age, iter, done_iter, exp_iter, wb_seen, fill_seen;
    bit exp_wb, done, fill_acked;
    logic [11:0] tg;
    logic [15:0] wb_addr, fill_addr;
    logic [31:0] wb_data;
    s = int'(addr[3:2]);
    tg = addr[15:4];
    fill_addr = {addr[15:2], 2'b00};
    hitw = -1;
    vic = -1;
    exp_wb = 0;
    wb_addr = '0;
    wb_data = '0;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hitw = w;
    if (hitw < 0) begin
      for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
      if (vic < 0) vic = m_rr[s];
      exp_wb  = m_valid[s][vic] && m_dirty[s][vic];
      wb_addr = {m_tag[s][vic], 2'(s), 2'b00};
      wb_data = m_data[s][vic];
    end
    exp_iter = (hitw >= 0) ? 0 : 1 + (delay + 1) + (exp_wb ? delay + 1 : 0);

    @(negedge clock);
    enable = 1'b1;
    write_or_read = wr;
    address = addr;
    in_data = wdata;
    age = 0; wb_seen = 0; fill_seen = 0; done = 0; fill_acked = 0; iter = 0; done_iter = 0;
    while (!done && iter < 200) begin
      #1;
      mem_ack = 1'b0;
      if (iter == 0 && hitw < 0) begin
        tests++;
        if (ready !== 1'b0 || out_data !== 32'h0) begin
          fails++;
          $display("FAIL %s miss_cycle: ready=%b out_data=%h, required ready=0 out_data=0", name, ready, out_data);
        end
      end
      if (drop_en ? (fill_acked && mem_req_valid === 1'b0) : (ready === 1'b1)) begin
        done = 1;
        done_iter = iter;
      end else begin
        if (mem_req_valid === 1'b1) begin
          if (drop_en && enable) begin
            enable = 1'b0;
            address = 16'($urandom);
            in_data = $urandom;
          end
          if (age == delay) begin
            if (mem_req_write === 1'b1) begin
              tests++;
              if (!exp_wb || wb_seen != 0 || mem_req_address !== wb_addr || mem_req_data !== wb_data) begin
                fails++;
                $display("FAIL %s writeback: addr=%h data=%h, required addr=%h data=%h (expected=%0b)",
                         name, mem_req_address, mem_req_data, wb_addr, wb_data, exp_wb);
              end
              wb_seen++;
              mem[wb_addr] = wb_data;
            end else begin
              tests++;
              if (hitw >= 0 || fill_seen != 0 || (exp_wb && wb_seen == 0) || mem_req_address !== fill_addr) begin
                fails++;
                $display("FAIL %s fill: addr=%h, required addr=%h (hit=%0b wb_pending=%0b)",
                         name, mem_req_address, fill_addr, hitw >= 0, exp_wb && wb_seen == 0);
              end
              mem_rdata = mem_read(mem_req_address);
              fill_seen++;
              fill_acked = 1;
            end
            mem_ack = 1'b1;
            age = 0;
          end else begin
            age++;
          end
        end
        @(negedge clock);
        iter++;
      end
    end
    mem_ack = 1'b0;

    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s timeout: no completion after %0d cycles, required %0d", name, iter, exp_iter);
    end else begin
      if (done_iter != exp_iter) begin
        fails++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, done_iter, exp_iter);
      end
      tests++;
      if (wb_seen != int'(exp_wb) || fill_seen != int'(hitw < 0)) begin
        fails++;
        $display("FAIL %s traffic: wb=%0d fill=%0d, required wb=%0d fill=%0d",
                 name, wb_seen, fill_seen, int'(exp_wb), int'(hitw < 0));
      end
      if (drop_en) begin
        tests++;
        if (ready !== 1'b1) begin
          fails++;
          $display("FAIL %s idle_ready: ready=%b, required 1", name, ready);
        end
      end
      way = hitw;
      if (hitw < 0) begin
        m_valid[s][vic] = 1;
        m_dirty[s][vic] = 0;
        m_tag[s][vic]   = tg;
        m_data[s][vic]  = mem_read(fill_addr);
        m_rr[s]         = (m_rr[s] + 1) % 2;
        way = vic;
      end
      if (!drop_en) begin
        if (wr) begin
          m_data[s][way]  = wdata;
          m_dirty[s][way] = 1;
        end else begin
          tests++;
          if (out_data !== m_data[s][way]) begin
            fails++;
            $display("FAIL %s read_data: out_data=%h, required %h", name, out_data, m_data[s][way]);
          end
        end
      end
      $display("[TB] %s %s addr=%h latency=%0d wb=%0d fill=%0d", name, wr ? "WRITE" : "READ",
               addr, done_iter, wb_seen, fill_seen);
    end
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || mem_req_write !== 1'b0 || mem_req_address !== 16'h0 || mem_req_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_mem_req: valid=%b write=%b addr=%h data=%h, required all 0",
               mem_req_valid, mem_req_write, mem_req_address, mem_req_data);
    end
    tests++;
    if (ready !== 1'b1 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b out_data=%h, required ready=1 out_data=0", ready, out_data);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1;
    tests++;
    if (ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b mem_req_valid=%b, required 1 and 0", ready, mem_req_valid);
    end
  endtask

  task automatic test_cold_miss();
    mem[16'h0010] = 32'hDEADBEEF;
    access(0, 16'h0010, 32'h0, 3, 0, "cold_miss");
    tests++;
    if (m_data[0][0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL cold_miss_line: installed=%h, required DEADBEEF", m_data[0][0]);
    end
    access(0, 16'h0010, 32'h0, 3, 0, "cold_rehit");
  endtask

  task automatic test_write_hit();
    access(1, 16'h0010, 32'h11111111, 2, 0, "write_hit");
    access(0, 16'h0010, 32'h0, 2, 0, "write_hit_rd");
  endtask

  task automatic test_invalid_way();
    access(0, 16'h0020, 32'h0, 1, 0, "invalid_way");
    access(0, 16'h0010, 32'h0, 1, 0, "invalid_way_rehit");
  endtask

  task automatic test_dirty_eviction();
    access(0, 16'h0030, 32'h0, 2, 0, "dirty_evict");
    access(0, 16'h0010, 32'h0, 1, 0, "evicted_remiss");
  endtask

  task automatic test_enable_drop();
    access(0, 16'h0040, 32'h0, 2, 1, "enable_drop");
    access(0, 16'h0040, 32'h0, 2, 0, "enable_drop_hit");
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    seen = 0;
    @(negedge clock);
    enable = 1'b1;
    write_or_read = 1'b0;
    address = 16'h0050;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_req_valid === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL reset_mid_fill_req: mem_req_valid never rose, required 1");
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || mem_req_address !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_fill_drop: mem_req_valid=%b addr=%h, required 0 and 0", mem_req_valid, mem_req_address);
    end
    enable = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    access(0, 16'h0010, 32'h0, 1, 0, "post_reset_miss");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      a = {12'($urandom_range(1, 6)), 2'($urandom), 2'($urandom)};
      access(1'($urandom), a, $urandom, $urandom_range(0, 3), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_invalid_way();
    test_dirty_eviction();
    test_enable_drop();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
Parametrised successor to the direct-mapped write-back cache. It is an N-way set-associative, write-back, write-allocate cache with an explicit miss FSM and a valid/ack request handshake to main memory. Per-set round-robin replacement prefers invalid ways. It sits between a pipeline stage (IF or MEM, selected by CACHE_TYPE) and the main-memory model.

Parameters:
ADDR_SIZE, 32, byte address width.
LINE_WIDTH, 128, line width in bits; multiple of 8, with LINE_WIDTH/8 a power of 2.
SETS, 4, number of sets; power of 2, at least 2.
WAYS, 2, associativity; power of 2, at least 1.
CACHE_TYPE, "DATA", label used in debug prints only.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  pipeline request valid.
write_or_read  in  1  1 = WRITE, 0 = READ.
address  in  ADDR_SIZE  byte address; offset bits are ignored.
in_data  in  LINE_WIDTH  write data (whole line).
out_data  out  LINE_WIDTH  read data; valid when ready & enable & READ.
ready  out  1  request complete this cycle.
mem_req_valid  out  1  memory request pending.
mem_req_write  out  1  1 = writeback, 0 = fill.
mem_req_address  out  ADDR_SIZE  line-aligned memory address.
mem_req_data  out  LINE_WIDTH  writeback data.
mem_ack  in  1  one-cycle acknowledge from memory.
mem_rdata  in  LINE_WIDTH  fill data; valid in the mem_ack cycle.

Behaviour:
- Address split: OFFSET = clog2(LINE_WIDTH/8), INDEX = clog2(SETS), TAG = ADDR_SIZE - INDEX - OFFSET; index = address[OFFSET+INDEX-1:OFFSET].
- Per-set state: WAYS x {valid, dirty, tag, data} plus one round-robin pointer rr[set] of clog2(WAYS) bits (0 bits when WAYS = 1).
- Reset (asynchronous, while reset_n = 0):
  - All valid, dirty and rr bits cleared; state = IDLE.
  - mem_req_valid = 0, mem_req_write = 0, mem_req_address = 0, mem_req_data = 0.
  - out_data = 0; ready = 1 when enable = 0.
  - Line data is not reset.
- Hit = some way in the set is valid with a matching tag; ways are unique by construction.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - ready = !enable | hit; out_data = data of the hit way (0 on miss), combinational.
  - Write hit: at the clock edge, data <= in_data and dirty <= 1. Zero-cycle latency.
  - Miss with enable:
    - Latch address, tag, index and the victim way.
    - Victim = lowest-index invalid way; if all ways are valid, victim = rr[set].
    - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_address = {victim tag, latched index, OFFSET zeros}; mem_req_data = victim data.
  - On mem_ack: dirty[victim] <= 0, go to FILL.
- FILL:
  - mem_req_valid = 1, mem_req_write = 0, mem_req_address = {latched tag, latched index, zeros}.
  - On mem_ack: data <= mem_rdata, tag <= latched tag, valid <= 1, dirty <= 0, rr[set] <= rr[set] + 1 (wraps modulo WAYS), go to IDLE.
- Request fields are registered and held stable while mem_req_valid = 1. The memory side must not ack when mem_req_valid = 0; the cache ignores mem_ack in IDLE.
- ready = 0 in WRITEBACK and FILL. The original request is retried in IDLE the cycle after the fill ack, where it hits.
- Miss latency = 1 + writeback handshake (if dirty) + fill handshake + 1 cycles.
- The requester holds enable, address, write_or_read and in_data until ready. Changes mid-miss do not alter the in-flight transaction, which always uses latched values.
- enable dropped mid-miss: the transaction completes, the line is installed, then the FSM returns to IDLE.
- Write miss: allocate via FILL, then the write hits in IDLE and the line becomes dirty.
- Reset mid-miss: the transaction is abandoned immediately and mem_req_valid drops asynchronously. The memory side must tolerate an abandoned request.

Decomposition:
- Package cache_pkg holds:
  - READ/WRITE constants;
  - state enum {IDLE, WRITEBACK, FILL};
  - a clog2 function;
  - derived OFFSET/INDEX/TAG width helpers.
- Sub-module cache_victim_select: purely combinational (valid vector, rr pointer) -> victim way index, with WAYS as a parameter.

Test Plan (ADDR_SIZE=16, LINE_WIDTH=32, SETS=4, WAYS=2; addresses 0x0010, 0x0020 and 0x0030 all map to set 0 with tags 1, 2 and 3):
1. Cold read miss:
   - Stimulus: after reset, READ 0x0010; memory acks 3 cycles after mem_req_valid with 0xDEADBEEF.
   - Response: fill request to 0x0010; ready = 1 and out_data = 0xDEADBEEF the cycle after ack.
   - Repeat READ 0x0010: ready in the same cycle, mem_req_valid stays 0.
2. Write hit: WRITE 0x0010 with 0x11111111 -> ready in the same cycle, no memory traffic; READ 0x0010 returns 0x11111111.
3. Invalid-way preference: READ 0x0020 -> fill only (no writeback) into way 1; 0x0010 still hits afterwards.
4. Dirty eviction: READ 0x0030 (rr[0] = 0) -> writeback to 0x0010 with data 0x11111111, then fill from 0x0030; a later READ 0x0010 misses again.
5. enable drop: deassert enable during FILL of 0x0040 -> fill completes; READ 0x0040 then hits with no memory traffic.
6. Reset mid-FILL: pull reset_n low while mem_req_valid = 1 -> mem_req_valid = 0 immediately; after release, READ 0x0010 misses (all lines invalid).
